// File: rtl/divu_unit.sv
// divu_unit: sequential unsigned divider, restoring shift-subtract, one
// quotient bit per clock. dataOut = {remainder, quotient} (Hi/Lo packing).
// Optional build macro: DIVU_DIV0_FLAG_EN adds the div_zero port and a
// one-cycle fast path for a zero divisor.
module divu_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   dataA,
  input  logic [WIDTH-1:0]   dataB,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] dataOut
`ifdef DIVU_DIV0_FLAG_EN
  ,
  output logic               div_zero
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  // Partial remainder is held in WIDTH bits: after each restoring step it is
  // always below the divisor, so the 33rd bit is only needed transiently.
  logic [WIDTH-1:0] r_rem;

  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_q_nx;

  // One restoring step: shift in the next dividend bit, trial-subtract D,
  // keep the difference when it did not borrow.
  always_comb begin
    w_rem_sh = {r_rem, r_q[WIDTH-1]};
    w_diff   = w_rem_sh - {1'b0, r_d};
    w_rem_nx = w_rem_sh[WIDTH-1:0];
    w_q_nx   = {r_q[WIDTH-2:0], 1'b0};
    if (!w_diff[WIDTH]) begin
      w_rem_nx  = w_diff[WIDTH-1:0];
      w_q_nx[0] = 1'b1;
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_q      <= '0;
      r_d      <= '0;
      r_rem    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dataOut  <= '0;
`ifdef DIVU_DIV0_FLAG_EN
      div_zero <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
`ifdef DIVU_DIV0_FLAG_EN
          div_zero <= 1'b0;
`endif
          if (start) begin
            r_q   <= dataA;
            r_d   <= dataB;
            r_rem <= '0;
            r_cnt <= '0;
`ifdef DIVU_DIV0_FLAG_EN
            // Zero divisor: emit the natural restoring result immediately.
            if (dataB == '0) begin
              r_state  <= S_DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              div_zero <= 1'b1;
              dataOut  <= {dataA, {WIDTH{1'b1}}};
            end else begin
              r_state <= S_RUN;
              busy    <= 1'b1;
            end
`else
            r_state <= S_RUN;
            busy    <= 1'b1;
`endif
          end else begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        end
        S_RUN: begin
          r_rem <= w_rem_nx;
          r_q   <= w_q_nx;
          if (r_cnt == CNT_LAST) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            dataOut <= {w_rem_nx, w_q_nx};
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divu_unit.sv
// tb_divu_unit: directed self-checking bench for divu_unit. Honors the
// DIVU_DIV0_FLAG_EN build macro for the div_zero port and zero-divisor timing.
module tb_divu_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic        busy;
  logic        done;
  logic [63:0] dataOut;
`ifdef DIVU_DIV0_FLAG_EN
  logic        div_zero;
`endif

  int n_cmp = 0;
  int n_err = 0;

  divu_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .dataA   (dataA),
    .dataB   (dataB),
    .busy    (busy),
    .done    (done),
    .dataOut (dataOut)
`ifdef DIVU_DIV0_FLAG_EN
    ,
    .div_zero(div_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present operands with start for one edge; afterwards we are in cycle 1.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    dataA = a;
    dataB = b;
    tick();
    start = 1'b0;
    dataA = 32'hDEAD_BEEF;
    dataB = 32'h0BAD_F00D;
  endtask

  // Wait (bounded) for done; lat is the cycle number at which done is seen.
  task automatic wait_done(input int from, output int lat, output int nbusy);
    lat   = from;
    nbusy = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (busy === 1'b1) nbusy++;
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int nb;
    int pulses;

    rst   = 1'b1;
    start = 1'b0;
    dataA = '0;
    dataB = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dout", dataOut, 64'd0);
`ifdef DIVU_DIV0_FLAG_EN
    chk("rst_dz", 64'(div_zero), 64'd0);
`endif

    // 100 / 7 = 14 r 2
    issue(32'd100, 32'd7);
    chk("b1_busy_c1", 64'(busy), 64'd1);
    wait_done(1, lat, nb);
    chk("b1_lat", 64'(lat), 64'd33);
    chk("b1_nbusy", 64'(nb), 64'd32);
    chk("b1_busy_done", 64'(busy), 64'd0);
    chk("b1_dout", dataOut, 64'h00000002_0000000E);
    tick();
    chk("b1_done_pulse", 64'(done), 64'd0);
    chk("b1_hold", dataOut, 64'h00000002_0000000E);

    // FFFFFFFF / 1
    issue(32'hFFFF_FFFF, 32'd1);
    wait_done(1, lat, nb);
    chk("b2_lat", 64'(lat), 64'd33);
    chk("b2_dout", dataOut, 64'h00000000_FFFFFFFF);
    tick();

    // 5 / FFFFFFFF
    issue(32'd5, 32'hFFFF_FFFF);
    wait_done(1, lat, nb);
    chk("b3_lat", 64'(lat), 64'd33);
    chk("b3_dout", dataOut, 64'h00000005_00000000);
    tick();

    // Divide by zero
    issue(32'h1234_5678, 32'd0);
    wait_done(1, lat, nb);
`ifdef DIVU_DIV0_FLAG_EN
    chk("dz_lat", 64'(lat), 64'd1);
    chk("dz_flag", 64'(div_zero), 64'd1);
`else
    chk("dz_lat", 64'(lat), 64'd33);
`endif
    chk("dz_dout", dataOut, 64'h12345678_FFFFFFFF);
    tick();
`ifdef DIVU_DIV0_FLAG_EN
    chk("dz_flag_clr", 64'(div_zero), 64'd0);
`endif

    // start during RUN is ignored
    issue(32'd100, 32'd7);
    for (int i = 0; i < 9; i++) tick();
    start = 1'b1;
    dataA = 32'd55;
    dataB = 32'd3;
    tick();
    start = 1'b0;
    wait_done(11, lat, nb);
    chk("ign_lat", 64'(lat), 64'd33);
    chk("ign_dout", dataOut, 64'h00000002_0000000E);
`ifdef DIVU_DIV0_FLAG_EN
    chk("ign_dz", 64'(div_zero), 64'd0);
`endif
    tick();

    // Reset in the middle of RUN
    issue(32'd100, 32'd7);
    for (int i = 0; i < 14; i++) tick();
    chk("mid_busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_done", 64'(done), 64'd0);
    chk("mid_dout", dataOut, 64'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) pulses++;
      tick();
    end
    chk("mid_no_done", 64'(pulses), 64'd0);

    // Back-to-back: 1000/10 then 9/4 with start held through DONE
    issue(32'd1000, 32'd10);
    wait_done(1, lat, nb);
    chk("bb1_lat", 64'(lat), 64'd33);
    chk("bb1_dout", dataOut, 64'h00000000_00000064);
    issue(32'd9, 32'd4);
    chk("bb2_busy_c1", 64'(busy), 64'd1);
    wait_done(1, lat, nb);
    chk("bb2_gap", 64'(lat), 64'd33);
    chk("bb2_dout", dataOut, 64'h00000001_00000002);
    tick();
    chk("bb2_idle_busy", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/divu_unit.md
# divu_unit

Sequential unsigned 32-bit divider; the division counterpart to the multiplier in the ALU datapath. It executes DIVU (function code 6'b011011, d27) by restoring shift-subtract, one quotient bit per clock. Its 64-bit result goes to the Hi/Lo register pair in the same packing the multiplier uses: remainder to Hi, quotient to Lo. The ALU control unit issues `start`; Hi/Lo captures `dataOut` on `done`.

## Interface
Parameters:
- `WIDTH`, 32, operand width; quotient and remainder are each `WIDTH` bits.

Ports:
- `clk`  in  1  rising-edge clock; the block's only clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a divide; sampled only in IDLE or DONE.
- `dataA`  in  WIDTH  dividend; latched on accepted `start`.
- `dataB`  in  WIDTH  divisor; latched on accepted `start`.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; `dataOut` is valid in this cycle.
- `dataOut`  out  2*WIDTH  {remainder, quotient}; [63:32] goes to Hi, [31:0] goes to Lo.
- `div_zero`  out  1  present only with `DIVU_DIV0_FLAG_EN`; see Configuration.

## Operation
- States:
  - IDLE.
  - RUN: counter `cnt`, 0..WIDTH-1.
  - DONE.
- IDLE + `start`: latch `dataA` into quotient register Q and `dataB` into divisor register D; clear the 33-bit partial remainder R; set `cnt`=0; go to RUN.
- RUN, each cycle:
  - Shift: R ← {R[31:0], Q[31]}, Q ← {Q[30:0], 0}.
  - Subtract: if R ≥ {0,D}, then R ← R − D and Q[0] ← 1.
  - When `cnt`=WIDTH-1, go to DONE; otherwise `cnt`++.
- DONE:
  - Drive `dataOut` = {R[31:0], Q} and assert `done`.
  - Next state is RUN if `start` (new operands latched), else IDLE.
- `dataOut` holds its last result through IDLE and RUN until the next DONE.
- `start` in RUN is ignored. There is no queueing, and the operation in progress is unaffected.
- Arithmetic is unsigned only. No overflow is possible.
- Divisor 0: the natural restoring result is Q=32'hFFFFFFFF, R=dividend. This result is required in both configurations.
- Reset values:
  - state IDLE, `cnt`=0.
  - `busy`=0, `done`=0, `dataOut`=0, `div_zero`=0.
- `rst` mid-RUN aborts the operation. No `done` is produced and `dataOut` returns to 0 on the next edge.

## Timing
- Cycle 0: `start` sampled in IDLE.
- Cycles 1..32: RUN, with `busy`=1.
- Cycle 33: DONE, with `done`=1 and `busy`=0. Latency from `start` to `done` is 33 cycles.
- Back-to-back operation: `start` held in the DONE cycle begins the next divide with no IDLE cycle, giving a throughput of one result per 33 cycles.
- All outputs are registered; there are no combinational paths from input to output.
- `rst` takes precedence over `start` in the same cycle.

## Configuration
- `DIVU_DIV0_FLAG_EN` defined:
  - The `div_zero` port exists.
  - When the latched divisor is 0, go directly from the accepting cycle to DONE, skipping RUN, so `done` arrives at cycle 1.
  - `dataOut` = {dividend, 32'hFFFFFFFF} and `div_zero`=1 in that DONE cycle.
  - `div_zero`=0 for every nonzero divisor and outside DONE.
- `DIVU_DIV0_FLAG_EN` undefined:
  - No `div_zero` port.
  - Divisor 0 runs the full 32 RUN cycles and produces the same `dataOut` values at cycle 33.

## Test plan
- 100 ÷ 7: `start` at cycle 0 → `busy` high for cycles 1–32; `done` at cycle 33 with `dataOut`=64'h00000002_0000000E.
- 32'hFFFFFFFF ÷ 1 → `dataOut`=64'h00000000_FFFFFFFF. Then 5 ÷ 32'hFFFFFFFF → `dataOut`=64'h00000005_00000000.
- Divisor 0 with dividend 32'h12345678 → `dataOut`=64'h12345678_FFFFFFFF:
  - With the macro: `done` at cycle 1 and `div_zero`=1.
  - Without the macro: `done` at cycle 33.
- `start` pulsed at cycle 10 of a 100÷7 run, with other operands on `dataA`/`dataB` → ignored; result is still 14 r 2 at cycle 33.
- Reset and back-to-back:
  - `rst` at cycle 15 → `busy`=0, `done` never pulses, `dataOut`=0.
  - Then 1000÷10 with `start` held high through its DONE cycle, followed by 9÷4 → results 100 r 0, then 2 r 1, with the two `done` pulses exactly 33 cycles apart.
